// File: rtl/aes_key_expand_if.sv
// ----------------------------------------------------------------------------
// aes_key_expand_if
// Purpose : bundles the strobe/key signals between the multicycle AES
//           controller and the on-the-fly round-key generator.
// Signals :
//   key_in     128  cipher key, [127:96]=w0 ... [31:0]=w3
//   key_load   1    capture key_in as round key 0
//   advance    1    compute the next round key
//   rewind     1    restore round key 0 from the stored cipher key
//   round_key  128  current round key (registered)
//   round_num  4    index of round_key
//   last_round 1    round_num has reached the final round
//   key_valid  1    a key has been loaded since reset
// Modports: master = controller side, slave = key generator side.
// ----------------------------------------------------------------------------
interface aes_key_expand_if;
   logic [127:0] key_in;
   logic         key_load;
   logic         advance;
   logic         rewind;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         last_round;
   logic         key_valid;

   modport master (
      output key_in, key_load, advance, rewind,
      input  round_key, round_num, last_round, key_valid
   );

   modport slave (
      input  key_in, key_load, advance, rewind,
      output round_key, round_num, last_round, key_valid
   );
endinterface

// File: rtl/aes_key_expand.sv
// ----------------------------------------------------------------------------
// aes_key_expand
// Purpose : on-the-fly AES-128 round-key generator. Holds the current round
//           key and derives the next one in a single clock per advance
//           strobe, so the round datapath never stores an 11-key schedule.
//           A copy of the cipher key is kept so the schedule can be rewound
//           to round 0 without reloading.
// Ports   :
//   clk   in   clock, all state updates on the rising edge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of aes_key_expand_if (strobes, key, round outputs)
// Parameters:
//   NR        number of rounds, only 10 (AES-128) is meaningful
//   RESET_KEY value of the round key and the cipher-key copy after reset
// Also contains aes_sbox, the combinational AES S-box used by SubWord.
// ----------------------------------------------------------------------------
module aes_key_expand #(
   parameter int           NR        = 10,
   parameter logic [127:0] RESET_KEY = 128'h0
) (
   input  logic              clk,
   input  logic              rst,
   aes_key_expand_if.slave   bus
);

   localparam logic [3:0] LastNum = 4'(NR);

   logic [127:0] r_roundKey;
   logic [127:0] r_keyCopy;
   logic [3:0]   r_roundNum;
   logic [7:0]   r_rcon;
   logic         r_lastRound;
   logic         r_keyValid;

   logic [31:0]  w_rotWord;
   logic [31:0]  w_subWord;
   logic [31:0]  w_temp;
   logic [31:0]  w_w0;
   logic [31:0]  w_w1;
   logic [31:0]  w_w2;
   logic [31:0]  w_w3;
   logic [127:0] w_nextKey;
   logic [7:0]   w_rconNext;
   logic [3:0]   w_numNext;
   logic         w_canAdvance;

   // RotWord rotates w3 left by one byte before SubWord.
   assign w_rotWord = {r_roundKey[23:0], r_roundKey[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : gSubWord
         aes_sbox uSbox (
            .i_in  (w_rotWord[gi*8 +: 8]),
            .o_out (w_subWord[gi*8 +: 8])
         );
      end
   endgenerate

   // Next round key: each new word chains off the previously produced word.
   assign w_temp     = w_subWord ^ {r_rcon, 24'h0};
   assign w_w0       = r_roundKey[127:96] ^ w_temp;
   assign w_w1       = r_roundKey[95:64]  ^ w_w0;
   assign w_w2       = r_roundKey[63:32]  ^ w_w1;
   assign w_w3       = r_roundKey[31:0]   ^ w_w2;
   assign w_nextKey  = {w_w0, w_w1, w_w2, w_w3};

   // Round constant doubles in GF(2^8) every round (xtime).
   assign w_rconNext = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

   assign w_numNext    = r_roundNum + 4'd1;
   assign w_canAdvance = r_keyValid && (r_roundNum < LastNum);

   // Key-schedule state. Strobe priority is load, then rewind, then advance;
   // rewind and advance are ignored until a key has been loaded, and advance
   // saturates at the final round instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_roundKey  <= RESET_KEY;
         r_keyCopy   <= RESET_KEY;
         r_roundNum  <= 4'd0;
         r_rcon      <= 8'h01;
         r_lastRound <= 1'b0;
         r_keyValid  <= 1'b0;
      end else if (bus.key_load) begin
         r_roundKey  <= bus.key_in;
         r_keyCopy   <= bus.key_in;
         r_roundNum  <= 4'd0;
         r_rcon      <= 8'h01;
         r_lastRound <= 1'b0;
         r_keyValid  <= 1'b1;
      end else if (bus.rewind && r_keyValid) begin
         r_roundKey  <= r_keyCopy;
         r_roundNum  <= 4'd0;
         r_rcon      <= 8'h01;
         r_lastRound <= 1'b0;
      end else if (bus.advance && w_canAdvance) begin
         r_roundKey  <= w_nextKey;
         r_roundNum  <= w_numNext;
         r_rcon      <= w_rconNext;
         r_lastRound <= (w_numNext == LastNum);
      end
   end

   assign bus.round_key  = r_roundKey;
   assign bus.round_num  = r_roundNum;
   assign bus.last_round = r_lastRound;
   assign bus.key_valid  = r_keyValid;

endmodule

// ----------------------------------------------------------------------------
// aes_sbox
// Purpose : combinational AES forward S-box lookup.
// Ports   : i_in byte in, o_out substituted byte out.
// ----------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] i_in,
   output logic [7:0] o_out
);

   // Entry 0 sits in the most significant byte so the table reads in
   // natural order, one row of 16 bytes per line.
   localparam logic [0:255][7:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_out = SboxTable[i_in];

endmodule
